// File: rtl/sram_burst_arbiter.sv
// Round-robin arbiter that shares one SRAM port between a burst read client and a burst write client.
// Each word takes ACCESS_CYCLES clocks. Every output is registered and driven from next-state values.
module sram_burst_arbiter #(
  parameter int ADDR_BITS     = 16,
  parameter int DATA_BITS     = 24,
  parameter int ACCESS_CYCLES = 4,
  parameter int MAX_BURST     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic [4:0]           rd_len,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [4:0]           rd_idx,
  output logic                 rd_valid,
  output logic                 rd_done,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [4:0]           wr_len,
  output logic [4:0]           wr_idx,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_done,
  output logic [ADDR_BITS-1:0] address,
  output logic [DATA_BITS-1:0] w_data,
  input  logic [DATA_BITS-1:0] r_data,
  output logic                 read_enable,
  output logic                 write_enable
);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  localparam logic [3:0] T_LAST  = 4'(ACCESS_CYCLES - 1);
  localparam logic [4:0] MAX_LEN = 5'(MAX_BURST);

  state_t               state, state_n;
  logic                 last_wr, last_wr_n;
  logic [ADDR_BITS-1:0] base, base_n;
  logic [4:0]           len, len_n;
  logic [4:0]           idx, idx_n, idx_inc;
  logic [3:0]           tcnt, tcnt_n;
  logic                 sample, grant_rd, grant_wr, word_end, last_word;
  logic [4:0]           rd_len_c, wr_len_c;

  logic [DATA_BITS-1:0] rd_data_n, w_data_n;
  logic [4:0]           rd_idx_n, wr_idx_n;
  logic                 rd_valid_n, rd_done_n, wr_done_n;
  logic [ADDR_BITS-1:0] address_n;
  logic                 read_enable_n, write_enable_n;

  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

  // The registered done strobes mark the first IDLE cycle, in which requests are not sampled.
  assign sample   = (state == IDLE) && !rd_done && !wr_done;
  assign grant_rd = sample && rd_req && (!wr_req || last_wr);
  assign grant_wr = sample && wr_req && !grant_rd;
  assign rd_len_c = clamp_len(rd_len);
  assign wr_len_c = clamp_len(wr_len);
  assign word_end  = (tcnt == T_LAST);
  assign last_word = (idx == len - 5'd1);
  assign idx_inc   = idx + 5'd1;

  always_comb begin
    state_n        = state;
    last_wr_n      = last_wr;
    base_n         = base;
    len_n          = len;
    idx_n          = idx;
    tcnt_n         = tcnt;
    rd_data_n      = rd_data;
    rd_idx_n       = rd_idx;
    rd_valid_n     = 1'b0;
    rd_done_n      = 1'b0;
    wr_idx_n       = wr_idx;
    wr_done_n      = 1'b0;
    address_n      = address;
    w_data_n       = w_data;
    read_enable_n  = 1'b0;
    write_enable_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_rd) begin
          last_wr_n = 1'b0;
          base_n    = rd_addr;
          len_n     = rd_len_c;
          idx_n     = '0;
          tcnt_n    = '0;
          address_n = rd_addr;
          if (rd_len_c == '0) begin
            rd_done_n = 1'b1;
          end else begin
            state_n       = RD_BURST;
            read_enable_n = 1'b1;
          end
        end else if (grant_wr) begin
          last_wr_n = 1'b1;
          base_n    = wr_addr;
          len_n     = wr_len_c;
          idx_n     = '0;
          tcnt_n    = '0;
          wr_idx_n  = '0;
          address_n = wr_addr;
          if (wr_len_c == '0) begin
            wr_done_n = 1'b1;
          end else begin
            state_n = WR_BURST;
          end
        end
      end

      RD_BURST: begin
        read_enable_n = 1'b1;
        if (word_end) begin
          rd_data_n  = r_data;
          rd_idx_n   = idx;
          rd_valid_n = 1'b1;
          if (last_word) begin
            state_n       = IDLE;
            read_enable_n = 1'b0;
            rd_done_n     = 1'b1;
          end else begin
            idx_n     = idx_inc;
            tcnt_n    = '0;
            address_n = base + ADDR_BITS'(idx_inc);
          end
        end else begin
          tcnt_n = tcnt + 4'd1;
        end
      end

      WR_BURST: begin
        if (word_end) begin
          if (last_word) begin
            state_n   = IDLE;
            wr_done_n = 1'b1;
          end else begin
            idx_n     = idx_inc;
            wr_idx_n  = idx_inc;
            tcnt_n    = '0;
            address_n = base + ADDR_BITS'(idx_inc);
          end
        end else begin
          // tcnt 0 is address setup: data is taken from the client, strobe rises next cycle.
          tcnt_n         = tcnt + 4'd1;
          write_enable_n = 1'b1;
          if (tcnt == '0) w_data_n = wr_data;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_wr      <= 1'b1;
      base         <= '0;
      len          <= '0;
      idx          <= '0;
      tcnt         <= '0;
      rd_data      <= '0;
      rd_idx       <= '0;
      rd_valid     <= 1'b0;
      rd_done      <= 1'b0;
      wr_idx       <= '0;
      wr_done      <= 1'b0;
      address      <= '0;
      w_data       <= '0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
    end else begin
      state        <= state_n;
      last_wr      <= last_wr_n;
      base         <= base_n;
      len          <= len_n;
      idx          <= idx_n;
      tcnt         <= tcnt_n;
      rd_data      <= rd_data_n;
      rd_idx       <= rd_idx_n;
      rd_valid     <= rd_valid_n;
      rd_done      <= rd_done_n;
      wr_idx       <= wr_idx_n;
      wr_done      <= wr_done_n;
      address      <= address_n;
      w_data       <= w_data_n;
      read_enable  <= read_enable_n;
      write_enable <= write_enable_n;
    end
  end

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Directed plus randomized bursts against sram_burst_arbiter, with per-cycle expectations derived
// from burst geometry (word = cycle / ACCESS_CYCLES) and a shadow memory of expected SRAM contents.
module tb_sram_burst_arbiter;

  localparam int AW = 16;
  localparam int DW = 24;
  localparam int AC = 4;
  localparam int MB = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [4:0]    rd_len, wr_len;
  logic [DW-1:0] rd_data, wr_data, w_data, r_data;
  logic [4:0]    rd_idx, wr_idx;
  logic          rd_valid, rd_done, wr_done;
  logic [AW-1:0] address;
  logic          read_enable, write_enable;

  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] wr_pat;

  int total = 0;
  int bad   = 0;

  sram_burst_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .ACCESS_CYCLES(AC), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_data(rd_data), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_idx(wr_idx), .wr_data(wr_data), .wr_done(wr_done),
    .address(address), .w_data(w_data), .r_data(r_data),
    .read_enable(read_enable), .write_enable(write_enable)
  );

  always #5 clk = ~clk;

  assign r_data  = mem[address];
  assign wr_data = wr_pat + DW'(wr_idx);

  always @(posedge clk) if (write_enable) mem[address] <= w_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".address"}, 32'(address), 0);
    chk({tag, ".re"}, 32'(read_enable), 0);
    chk({tag, ".we"}, 32'(write_enable), 0);
    chk({tag, ".w_data"}, 32'(w_data), 0);
    chk({tag, ".rd_data"}, 32'(rd_data), 0);
    chk({tag, ".rd_idx"}, 32'(rd_idx), 0);
    chk({tag, ".wr_idx"}, 32'(wr_idx), 0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 0);
    chk({tag, ".rd_done"}, 32'(rd_done), 0);
    chk({tag, ".wr_done"}, 32'(wr_done), 0);
  endtask

  // Called at a negedge in an IDLE cycle where requests are sampled; the next posedge is the grant.
  task automatic run_burst(input bit is_wr, input logic [AW-1:0] base, input logic [4:0] len);
    int n;
    int last_c;
    n = (int'(len) > MB) ? MB : int'(len);
    last_c = n * AC + 1;
    if (is_wr) begin
      wr_req = 1'b1; wr_addr = base; wr_len = len;
    end else begin
      rd_req = 1'b1; rd_addr = base; rd_len = len;
    end
    @(posedge clk);
    for (int c = 1; c <= last_c; c++) begin
      int w;
      int t;
      bit fin;
      bit exp_valid;
      logic [AW-1:0] ea;
      @(negedge clk);
      w = (c - 1) / AC;
      t = (c - 1) % AC;
      fin = (c == last_c);
      ea = base + AW'(w);
      if (!fin) begin
        chk("address", 32'(address), 32'(ea));
        chk("read_enable", 32'(read_enable), 32'(!is_wr));
        chk("write_enable", 32'(write_enable), 32'(is_wr && t != 0));
        if (is_wr) chk("wr_idx", 32'(wr_idx), 32'(w));
        if (is_wr && t != 0) chk("w_data", 32'(w_data), 32'(wr_pat + DW'(w)));
      end else begin
        chk("end.read_enable", 32'(read_enable), 0);
        chk("end.write_enable", 32'(write_enable), 0);
      end
      exp_valid = !is_wr && c > 1 && t == 0;
      chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("rd_idx", 32'(rd_idx), 32'(w - 1));
        chk("rd_data", 32'(rd_data), 32'(ref_mem[base + AW'(w - 1)]));
      end
      chk("rd_done", 32'(rd_done), 32'(fin && !is_wr));
      chk("wr_done", 32'(wr_done), 32'(fin && is_wr));
      if (fin) begin
        if (is_wr) wr_req = 1'b0; else rd_req = 1'b0;
      end
    end
    if (is_wr) for (int i = 0; i < n; i++) ref_mem[base + AW'(i)] = wr_pat + DW'(i);
    @(posedge clk);
    @(negedge clk);
    chk("post.rd_done", 32'(rd_done), 0);
    chk("post.wr_done", 32'(wr_done), 0);
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = DW'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    rst = 1'b1;
    rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
    wr_pat = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Tie straight after reset: read first, then held requests alternate.
    wr_req = 1'b1; wr_addr = 16'h2000; wr_len = 5'd2; wr_pat = 24'h0000A0;
    run_burst(1'b0, 16'h0100, 5'd3);
    rd_req = 1'b1;
    run_burst(1'b1, 16'h2000, 5'd2);
    wr_req = 1'b1; wr_addr = 16'h2100; wr_len = 5'd1; wr_pat = 24'h0000B0;
    run_burst(1'b0, 16'h1FFF, 5'd4);
    run_burst(1'b1, 16'h2100, 5'd1);

    // Address wrap, zero length, clamp.
    run_burst(1'b0, 16'hFFFF, 5'd2);
    run_burst(1'b0, 16'h0040, 5'd0);
    wr_pat = 24'h123400;
    run_burst(1'b1, 16'h0050, 5'd0);
    run_burst(1'b0, 16'h4000, 5'd25);
    wr_pat = 24'h5A5A00;
    run_burst(1'b1, 16'h4000, 5'd31);
    run_burst(1'b0, 16'h4000, 5'd22);

    // Randomized write/read-back pairs.
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0] b;
      logic [4:0] l;
      b = AW'($urandom);
      l = 5'($urandom_range(0, 31));
      wr_pat = DW'($urandom);
      run_burst(1'b1, b, l);
      run_burst(1'b0, b - AW'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    end

    // Asynchronous reset in cycle 6 of a 3-word write.
    wr_pat = 24'hC0FFEE;
    wr_req = 1'b1; wr_addr = 16'h3000; wr_len = 5'd3;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    wr_req = 1'b0;
    #1;
    chk_all_zero("abort");
    ref_mem[16'h3000] = wr_pat;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort.wr_done", 32'(wr_done), 0);
      chk("abort.we", 32'(write_enable), 0);
    end
    run_burst(1'b0, 16'h3000, 5'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
